// File: rtl/gate_seq_3l_multi.sv
// gate_seq_3l_multi: multi-leg 3-level NPC/ANPC gate sequencer.
// Ports: clk, rst (sync, active-high), ce, t_dead, t_min, topo, v_lev,
//   fault/fault_clr (GSEQ_FAULT_EN only) -> s_out, lev_out, busy, tripped.
// Each leg runs OFF/DEAD/HOLD with break-before-make dead time and a
// minimum dwell; P<->N always steps through the zero level.
// Optional trip latch is enabled by defining GSEQ_FAULT_EN.
module gate_seq_3l_multi #(
    parameter int N_LEG = 3,
    parameter int TW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [TW-1:0]      t_dead,
    input  logic [TW-1:0]      t_min,
    input  logic [1:0]         topo,
    input  logic [2*N_LEG-1:0] v_lev,
`ifdef GSEQ_FAULT_EN
    input  logic               fault,
    input  logic               fault_clr,
`endif
    output logic [6*N_LEG-1:0] s_out,
    output logic [2*N_LEG-1:0] lev_out,
    output logic [N_LEG-1:0]   busy,
    output logic               tripped
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DEAD,
        ST_HOLD
    } state_t;

    localparam logic [1:0] LEV_N = 2'b00;
    localparam logic [1:0] LEV_Z = 2'b01;
    localparam logic [1:0] LEV_P = 2'b10;
    // No level applied yet: gate code is all-off.
    localparam logic [1:0] LEV_X = 2'b11;

    localparam logic [TW-1:0] CNT_ONE = {{(TW-1){1'b0}}, 1'b1};

    function automatic logic [5:0] lev_code(
        input logic [1:0] tp,
        input logic [1:0] lev
    );
        logic [5:0] c;
        c = 6'b000000;
        case (lev)
            LEV_P:   c = (tp == 2'd3) ? 6'b110001 : 6'b110000;
            LEV_Z:   c = (tp == 2'd3) ? 6'b011011 : 6'b011000;
            LEV_N:   c = (tp == 2'd3) ? 6'b001110 : 6'b001100;
            default: c = 6'b000000;
        endcase
        if (tp != 2'd1 && tp != 2'd3) begin
            c = 6'b000000;
        end
        return c;
    endfunction

    logic [1:0]    topo_eff;
    logic [1:0]    topo_q;
    logic [1:0]    topo_n;
    logic          reseed;
    logic          trip_q;
    logic [TW-1:0] td_eff;

    // Reserved topology code behaves as off.
    assign topo_eff = (topo == 2'd1 || topo == 2'd3) ? topo : 2'd0;
    assign td_eff   = (t_dead == '0) ? CNT_ONE : t_dead;

    // Topology is tracked per ce-cycle; a trip forgets it so that
    // clearing the trip re-seeds legs exactly as from OFF.
    always_comb begin
        topo_n = topo_q;
        reseed = 1'b0;
        if (trip_q) begin
            topo_n = 2'd0;
        end else if (ce) begin
            topo_n = topo_eff;
            reseed = (topo_q != 2'd0) && (topo_eff != 2'd0)
                     && (topo_eff != topo_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            topo_q <= 2'd0;
        end else begin
            topo_q <= topo_n;
        end
    end

`ifdef GSEQ_FAULT_EN
    // Trip latch runs on every clk; set wins over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            trip_q <= 1'b0;
        end else if (fault) begin
            trip_q <= 1'b1;
        end else if (fault_clr) begin
            trip_q <= 1'b0;
        end
    end
`else
    assign trip_q = 1'b0;
`endif

    assign tripped = trip_q;

    for (genvar g = 0; g < N_LEG; g++) begin : g_leg
        state_t        st_q, st_d;
        logic [1:0]    cur_q, cur_d;
        logic [1:0]    tgt_q, tgt_d;
        logic [TW-1:0] dcnt_q, dcnt_d;
        logic [TW-1:0] wcnt_q, wcnt_d;
        logic [TW-1:0] wnext;
        logic [1:0]    req;
        logic [1:0]    step_lev;
        logic [5:0]    s_d, s_q;
        logic [1:0]    lev_d, lev_q;
        logic          busy_d, busy_q;

        assign req   = v_lev[2*g +: 2];
        assign wnext = (wcnt_q == '0) ? '0 : wcnt_q - CNT_ONE;
        // One step toward the request: P<->N goes via zero.
        assign step_lev = (cur_q == LEV_Z || req == LEV_Z) ? req : LEV_Z;

        always_comb begin
            st_d   = st_q;
            cur_d  = cur_q;
            tgt_d  = tgt_q;
            dcnt_d = dcnt_q;
            wcnt_d = wcnt_q;
            if (trip_q || (ce && topo_eff == 2'd0)) begin
                st_d   = ST_OFF;
                cur_d  = LEV_X;
                tgt_d  = LEV_X;
                dcnt_d = '0;
                wcnt_d = '0;
            end else if (ce && (st_q == ST_OFF || reseed)) begin
                st_d   = ST_DEAD;
                cur_d  = LEV_X;
                tgt_d  = LEV_Z;
                dcnt_d = td_eff;
                wcnt_d = '0;
            end else if (ce) begin
                unique case (st_q)
                    ST_DEAD: begin
                        if (dcnt_q <= CNT_ONE) begin
                            st_d   = ST_HOLD;
                            cur_d  = tgt_q;
                            dcnt_d = '0;
                            wcnt_d = t_min;
                        end else begin
                            dcnt_d = dcnt_q - CNT_ONE;
                        end
                    end
                    ST_HOLD: begin
                        wcnt_d = wnext;
                        if (wnext == '0 && req != LEV_X
                            && req != cur_q) begin
                            st_d   = ST_DEAD;
                            tgt_d  = step_lev;
                            dcnt_d = td_eff;
                        end
                    end
                    default: begin
                        st_d = ST_OFF;
                    end
                endcase
            end
        end

        // Outputs are decoded from next state and registered.
        always_comb begin
            s_d    = 6'b000000;
            busy_d = 1'b0;
            lev_d  = (cur_d == LEV_X) ? LEV_Z : cur_d;
            unique case (st_d)
                ST_DEAD: begin
                    s_d    = lev_code(topo_n, cur_d)
                             & lev_code(topo_n, tgt_d);
                    busy_d = 1'b1;
                end
                ST_HOLD: begin
                    s_d    = lev_code(topo_n, cur_d);
                    busy_d = (wcnt_d != '0);
                end
                default: begin
                    s_d = 6'b000000;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q   <= ST_OFF;
                cur_q  <= LEV_X;
                tgt_q  <= LEV_X;
                dcnt_q <= '0;
                wcnt_q <= '0;
                s_q    <= 6'b000000;
                lev_q  <= LEV_Z;
                busy_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                cur_q  <= cur_d;
                tgt_q  <= tgt_d;
                dcnt_q <= dcnt_d;
                wcnt_q <= wcnt_d;
                s_q    <= s_d;
                lev_q  <= lev_d;
                busy_q <= busy_d;
            end
        end

        assign s_out[6*g +: 6]   = s_q;
        assign lev_out[2*g +: 2] = lev_q;
        assign busy[g]           = busy_q;
    end

endmodule

// File: tb/tb_gate_seq_3l_multi.sv
// tb_gate_seq_3l_multi: directed + random bench for gate_seq_3l_multi.
// Reference model tracks each leg with ce-tick timestamps.
module tb_gate_seq_3l_multi;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [7:0]  t_dead;
    logic [7:0]  t_min;
    logic [1:0]  topo;
    logic [5:0]  v_lev;
`ifdef GSEQ_FAULT_EN
    logic        fault;
    logic        fault_clr;
`endif
    logic [17:0] s_out;
    logic [5:0]  lev_out;
    logic [2:0]  busy;
    logic        tripped;

    always #5 clk = ~clk;

    gate_seq_3l_multi #(.N_LEG(N), .TW(8)) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .t_dead(t_dead),
        .t_min(t_min),
        .topo(topo),
        .v_lev(v_lev),
`ifdef GSEQ_FAULT_EN
        .fault(fault),
        .fault_clr(fault_clr),
`endif
        .s_out(s_out),
        .lev_out(lev_out),
        .busy(busy),
        .tripped(tripped)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: levels as integers -1/0/+1, -2 = nothing applied.
    bit m_on[N];
    bit m_dead[N];
    int m_cur[N];
    int m_tgt[N];
    int m_dend[N];
    int m_hent[N];
    int m_tmin[N];
    int m_topo = 0;
    int m_tick = 0;
    bit m_trip = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    function automatic logic [5:0] code(input int tp, input int lev);
        if (tp == 1) begin
            case (lev)
                1:       return 6'b110000;
                0:       return 6'b011000;
                -1:      return 6'b001100;
                default: return 6'b000000;
            endcase
        end
        if (tp == 3) begin
            case (lev)
                1:       return 6'b110001;
                0:       return 6'b011011;
                -1:      return 6'b001110;
                default: return 6'b000000;
            endcase
        end
        return 6'b000000;
    endfunction

    task automatic leg_off(input int i);
        m_on[i]   = 1'b0;
        m_dead[i] = 1'b0;
        m_cur[i]  = -2;
        m_tgt[i]  = -2;
        m_hent[i] = 0;
        m_tmin[i] = 0;
    endtask

    task automatic model_edge();
        bit ot;
        int te, td, e, rl, mt;
        ot = m_trip;
        if (rst) begin
            for (int i = 0; i < N; i++) leg_off(i);
            m_topo = 0;
            m_trip = 1'b0;
            return;
        end
        if (ot) begin
            for (int i = 0; i < N; i++) leg_off(i);
            m_topo = 0;
        end else if (ce) begin
            te = (topo == 2'd1 || topo == 2'd3) ? int'(topo) : 0;
            td = (t_dead == 8'd0) ? 1 : int'(t_dead);
            e  = m_tick;
            for (int i = 0; i < N; i++) begin
                rl = int'(v_lev[2*i +: 2]) - 1;
                mt = (m_tmin[i] == 0) ? 1 : m_tmin[i];
                if (te == 0) begin
                    leg_off(i);
                end else if (!m_on[i] || (m_topo != 0 && te != m_topo)) begin
                    m_on[i]   = 1'b1;
                    m_dead[i] = 1'b1;
                    m_cur[i]  = -2;
                    m_tgt[i]  = 0;
                    m_dend[i] = e + td;
                    m_hent[i] = 0;
                    m_tmin[i] = 0;
                end else if (m_dead[i]) begin
                    if (e >= m_dend[i]) begin
                        m_cur[i]  = m_tgt[i];
                        m_dead[i] = 1'b0;
                        m_hent[i] = e;
                        m_tmin[i] = int'(t_min);
                    end
                end else if (rl != 2 && rl != m_cur[i]
                             && e >= m_hent[i] + mt) begin
                    m_tgt[i]  = m_cur[i] + ((rl > m_cur[i]) ? 1 : -1);
                    m_dead[i] = 1'b1;
                    m_dend[i] = e + td;
                end
            end
            m_topo = te;
            m_tick++;
        end
`ifdef GSEQ_FAULT_EN
        if (fault) m_trip = 1'b1;
        else if (fault_clr) m_trip = 1'b0;
`endif
    endtask

    task automatic check_all(input string tag);
        logic [17:0] es;
        logic [5:0]  el;
        logic [2:0]  eb;
        logic        bad_pair;
        int          last;
        last = m_tick - 1;
        for (int i = 0; i < N; i++) begin
            if (!m_on[i]) es[6*i +: 6] = 6'b0;
            else if (m_dead[i])
                es[6*i +: 6] = code(m_topo, m_cur[i]) & code(m_topo, m_tgt[i]);
            else es[6*i +: 6] = code(m_topo, m_cur[i]);
            el[2*i +: 2] = (m_cur[i] == -2) ? 2'b01 : 2'(m_cur[i] + 1);
            eb[i] = m_on[i] && (m_dead[i] || last < m_hent[i] + m_tmin[i]);
        end
        chk({tag, "/s_out"}, 32'(s_out), 32'(es));
        chk({tag, "/lev_out"}, 32'(lev_out), 32'(el));
        chk({tag, "/busy"}, 32'(busy), 32'(eb));
        chk({tag, "/tripped"}, 32'(tripped), 32'(m_trip));
        for (int i = 0; i < N; i++) begin
            bad_pair = (s_out[6*i+5] & s_out[6*i+3])
                       | (s_out[6*i+4] & s_out[6*i+2]);
            chk({tag, "/shoot"}, 32'(bad_pair), 32'd0);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int cnt;
        logic [5:0] want;
        for (int i = 0; i < N; i++) leg_off(i);
        rst    = 1'b1;
        ce     = 1'b1;
        topo   = 2'd0;
        t_dead = 8'd3;
        t_min  = 8'd0;
        v_lev  = 6'b010101;
`ifdef GSEQ_FAULT_EN
        fault     = 1'b0;
        fault_clr = 1'b0;
`endif
        step("rst");
        step("rst");
        chk("rst_s", 32'(s_out), 32'd0);
        chk("rst_lev", 32'(lev_out), 32'h15);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_trip", 32'(tripped), 32'd0);

        // NPC start-up
        rst  = 1'b0;
        topo = 2'd1;
        for (int k = 0; k < 4; k++) begin
            step("start");
            want = (k < 3) ? 6'b000000 : 6'b011000;
            chk("start_leg0", 32'(s_out[5:0]), 32'(want));
        end
        chk("start_lev", 32'(lev_out[1:0]), 32'd1);

        // Leg 0 to P, then P->N through zero
        t_dead = 8'd2;
        v_lev  = 6'b010110;
        for (int k = 0; k < 4; k++) step("to_p");
        chk("at_p", 32'(s_out[5:0]), 32'h30);
        t_min = 8'd4;
        v_lev = 6'b010100;
        for (int k = 0; k < 9; k++) begin
            step("p2n");
            if (k < 2) want = 6'b010000;
            else if (k < 6) want = 6'b011000;
            else if (k < 8) want = 6'b001000;
            else want = 6'b001100;
            chk("p2n_leg0", 32'(s_out[5:0]), 32'(want));
        end

        // NPC -> ANPC re-seed, then ANPC 0->P on leg 0
        t_min  = 8'd0;
        t_dead = 8'd1;
        v_lev  = 6'b010101;
        topo   = 2'd3;
        step("anpc_seed");
        chk("anpc_seed_s", 32'(s_out), 32'd0);
        step("anpc_zero");
        chk("anpc_zero_s", 32'(s_out), 32'({3{6'b011011}}));
        v_lev = 6'b010110;
        step("anpc_0p");
        chk("anpc_dead", 32'(s_out), 32'({6'b011011, 6'b011011, 6'b010001}));
        step("anpc_0p");
        chk("anpc_p", 32'(s_out), 32'({6'b011011, 6'b011011, 6'b110001}));

        // ANPC -> NPC while leg 0 holds P, then off
        v_lev = 6'b010101;
        topo  = 2'd1;
        step("npc_seed");
        chk("npc_seed_s", 32'(s_out), 32'd0);
        step("npc_zero");
        chk("npc_zero_s", 32'(s_out), 32'({3{6'b011000}}));
        topo = 2'd0;
        step("off");
        chk("off_s", 32'(s_out), 32'd0);

        // ce gating: one enable in four stretches DEAD to 8 clocks
        topo   = 2'd1;
        t_dead = 8'd2;
        for (int k = 0; k < 3; k++) step("ce_seed");
        v_lev = 6'b010110;
        cnt   = 0;
        for (int k = 0; k < 16; k++) begin
            ce = (k % 4 == 0);
            step("ce_gate");
            if (s_out[5:0] == 6'b010000) cnt++;
        end
        chk("ce_dead_len", 32'(cnt), 32'd8);
        chk("ce_end_p", 32'(s_out[5:0]), 32'h30);
        ce = 1'b1;

`ifdef GSEQ_FAULT_EN
        // Trip mid-DEAD with ce low, then clear and re-seed
        v_lev = 6'b010101;
        step("f_dead");
        ce    = 1'b0;
        fault = 1'b1;
        step("f_set");
        chk("f_set_trip", 32'(tripped), 32'd1);
        fault = 1'b0;
        step("f_off");
        chk("f_off_s", 32'(s_out), 32'd0);
        fault     = 1'b1;
        fault_clr = 1'b1;
        step("f_both");
        chk("f_both_trip", 32'(tripped), 32'd1);
        fault = 1'b0;
        ce    = 1'b1;
        step("f_clr");
        chk("f_clr_trip", 32'(tripped), 32'd0);
        fault_clr = 1'b0;
        for (int k = 0; k < 4; k++) step("f_reseed");
        chk("f_reseed_s", 32'(s_out), 32'({3{6'b011000}}));
        chk("f_reseed_lev", 32'(lev_out), 32'h15);
`endif

        // Random phase
        for (int k = 0; k < 600; k++) begin
            ce  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) == 0) topo = 2'($urandom_range(0, 3));
                else topo = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3;
            end
            if ($urandom_range(0, 3) == 0) v_lev = 6'($urandom);
            t_dead = 8'($urandom_range(0, 3));
            t_min  = 8'($urandom_range(0, 5));
`ifdef GSEQ_FAULT_EN
            fault     = ($urandom_range(0, 99) == 0);
            fault_clr = ($urandom_range(0, 9) == 0);
`endif
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
